// File: rtl/esm_config_decoder.sv
// ESM control message receive decoder: checks the 4-word header (magic, sequence, module/type, pad)
// and emits payload words tagged with module ID, message type and word index.
module esm_config_decoder #(
   parameter int          AXI_DATA_WIDTH = 32,
   parameter logic [31:0] MAGIC_NUM      = 32'hE5C0_0001,
   parameter int          INDEX_WIDTH    = 8
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      S_axis_valid,
   output logic                      S_axis_ready,
   input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
   input  logic                      S_axis_last,
   output logic                      Cfg_valid,
   output logic [7:0]                Cfg_module_id,
   output logic [7:0]                Cfg_message_type,
   output logic [INDEX_WIDTH-1:0]    Cfg_index,
   output logic [AXI_DATA_WIDTH-1:0] Cfg_data,
   output logic                      Cfg_last,
   output logic [AXI_DATA_WIDTH-1:0] Cfg_seq_num,
   output logic                      Err_magic,
   output logic                      Err_seq,
   output logic                      Err_short,
   output logic                      Err_length,
   output logic [15:0]               Msg_count
);

   typedef enum logic [2:0] {
      S_MAGIC,
      S_SEQ,
      S_HEADER,
      S_PAD,
      S_PAYLOAD,
      S_DRAIN
   } state_t;

   localparam logic [INDEX_WIDTH:0]      IDX_ONE = 1;
   localparam logic [AXI_DATA_WIDTH-1:0] SEQ_ONE = 1;

   state_t                    state_q, state_d;
   logic                      ready_q, ready_d;
   logic                      valid_q, valid_d;
   logic                      last_q, last_d;
   logic [INDEX_WIDTH-1:0]    index_q, index_d;
   logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
   logic [7:0]                module_q, module_d;
   logic [7:0]                type_q, type_d;
   logic [AXI_DATA_WIDTH-1:0] seq_q, seq_d;
   logic                      seq_ok_q, seq_ok_d;
   logic                      err_magic_q, err_magic_d;
   logic                      err_seq_q, err_seq_d;
   logic                      err_short_q, err_short_d;
   logic                      err_length_q, err_length_d;
   logic [15:0]               count_q, count_d;
   // One extra bit: the MSB set means 2^INDEX_WIDTH words have already been emitted.
   logic [INDEX_WIDTH:0]      idx_q, idx_d;
   logic                      accept;

   assign accept = S_axis_valid && ready_q;

   always_comb begin
      state_d      = state_q;
      ready_d      = 1'b1;
      valid_d      = 1'b0;
      last_d       = 1'b0;
      index_d      = index_q;
      data_d       = data_q;
      module_d     = module_q;
      type_d       = type_q;
      seq_d        = seq_q;
      seq_ok_d     = seq_ok_q;
      err_magic_d  = 1'b0;
      err_seq_d    = 1'b0;
      err_short_d  = 1'b0;
      err_length_d = 1'b0;
      count_d      = count_q;
      idx_d        = idx_q;
      if (accept) begin
         case (state_q)
            S_MAGIC: begin
               if (S_axis_data == MAGIC_NUM) begin
                  err_short_d = S_axis_last;
                  state_d     = S_axis_last ? S_MAGIC : S_SEQ;
               end else begin
                  err_magic_d = 1'b1;
                  state_d     = S_axis_last ? S_MAGIC : S_DRAIN;
               end
            end
            S_SEQ: begin
               err_seq_d   = seq_ok_q && (S_axis_data != seq_q + SEQ_ONE);
               seq_d       = S_axis_data;
               seq_ok_d    = 1'b1;
               err_short_d = S_axis_last;
               state_d     = S_axis_last ? S_MAGIC : S_HEADER;
            end
            S_HEADER: begin
               module_d    = S_axis_data[31:24];
               type_d      = S_axis_data[23:16];
               err_short_d = S_axis_last;
               state_d     = S_axis_last ? S_MAGIC : S_PAD;
            end
            S_PAD: begin
               count_d = count_q + 16'd1;
               idx_d   = '0;
               state_d = S_axis_last ? S_MAGIC : S_PAYLOAD;
            end
            S_PAYLOAD: begin
               if (idx_q[INDEX_WIDTH]) begin
                  // Over-length word is dropped; a last here closes the message directly.
                  err_length_d = 1'b1;
                  state_d      = S_axis_last ? S_MAGIC : S_DRAIN;
               end else begin
                  valid_d = 1'b1;
                  last_d  = S_axis_last;
                  data_d  = S_axis_data;
                  index_d = idx_q[INDEX_WIDTH-1:0];
                  idx_d   = idx_q + IDX_ONE;
                  if (S_axis_last) state_d = S_MAGIC;
               end
            end
            S_DRAIN: begin
               if (S_axis_last) state_d = S_MAGIC;
            end
            default: state_d = S_MAGIC;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q      <= S_MAGIC;
         ready_q      <= 1'b0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         index_q      <= '0;
         data_q       <= '0;
         module_q     <= '0;
         type_q       <= '0;
         seq_q        <= '0;
         seq_ok_q     <= 1'b0;
         err_magic_q  <= 1'b0;
         err_seq_q    <= 1'b0;
         err_short_q  <= 1'b0;
         err_length_q <= 1'b0;
         count_q      <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         valid_q      <= valid_d;
         last_q       <= last_d;
         index_q      <= index_d;
         data_q       <= data_d;
         module_q     <= module_d;
         type_q       <= type_d;
         seq_q        <= seq_d;
         seq_ok_q     <= seq_ok_d;
         err_magic_q  <= err_magic_d;
         err_seq_q    <= err_seq_d;
         err_short_q  <= err_short_d;
         err_length_q <= err_length_d;
         count_q      <= count_d;
         idx_q        <= idx_d;
      end
   end

   assign S_axis_ready     = ready_q;
   assign Cfg_valid        = valid_q;
   assign Cfg_last         = last_q;
   assign Cfg_index        = index_q;
   assign Cfg_data         = data_q;
   assign Cfg_module_id    = module_q;
   assign Cfg_message_type = type_q;
   assign Cfg_seq_num      = seq_q;
   assign Err_magic        = err_magic_q;
   assign Err_seq          = err_seq_q;
   assign Err_short        = err_short_q;
   assign Err_length       = err_length_q;
   assign Msg_count        = count_q;

endmodule
